fault_row_matcher: RTL

FAULT_ROW_MATCHER -- requirements
Module: fault_row_matcher

---
 rtl/fault_row_matcher_pkg.sv | 16 +
 rtl/fault_row_matcher_priority_finder.sv | 29 ++
 rtl/fault_row_matcher.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fault_row_matcher_pkg.sv
// Shared accelerator definitions for the fault-row matcher: array geometry
// defaults and the matcher FSM state encoding.
package fault_row_matcher_pkg;

   localparam int unsigned DEF_SYSTOLIC_SIZE = 8;
   localparam int unsigned DEF_ADDR_WIDTH    = $clog2(DEF_SYSTOLIC_SIZE);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_COMMIT   = 3'd1,
      ST_WAIT_ROW = 3'd2,
      ST_ISSUE    = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

endpackage

// File: rtl/fault_row_matcher_priority_finder.sv
// Lowest-index set-bit finder over the candidate-row vector.
// Ports:
//   candidates : one bit per row, 1 = row may absorb the current weight row
//   index      : lowest set bit position (0 when none set)
//   found      : at least one candidate bit set
module fault_row_priority_finder
   import fault_row_matcher_pkg::*;
#(
   parameter int unsigned SYSTOLIC_SIZE = DEF_SYSTOLIC_SIZE,
   parameter int unsigned ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
) (
   input  logic [SYSTOLIC_SIZE-1:0] candidates,
   output logic [ADDR_WIDTH-1:0]    index,
   output logic                     found
);

   // Scan high to low so the lowest set bit is the last one written.
   always_comb begin
      index = '0;
      found = 1'b0;
      for (int i = int'(SYSTOLIC_SIZE) - 1; i >= 0; i--) begin
         if (candidates[i]) begin
            index = ADDR_WIDTH'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fault_row_matcher.sv
// Matches incoming weight rows against rows of the systolic array containing
// faulty PEs: a faulty row can host a weight row if every faulty column of
// that row carries a zero weight.
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   fault_wr_en/row/cols        : load one row's faulty-column mask (IDLE only)
//   load_done                   : commit fault map and start a matching pass
//   weight_row_valid/ready      : handshake for one weight-row zero mask
//   weight_zero_mask            : bit c = 1 when the weight in column c is zero
//   faulty_rows_mask            : rows containing any faulty PE
//   envm_wr_en                  : one-cycle commit pulse
//   match_success/match_failed/all_faulty_matched : one-cycle per-row result
//   faulty_addr                 : faulty row chosen (0 unless match_success)
//   current_row_addr            : weight-row index of the current result
//   busy, done                  : pass in progress, end-of-pass pulse
module fault_row_matcher
   import fault_row_matcher_pkg::*;
#(
   parameter int unsigned SYSTOLIC_SIZE = DEF_SYSTOLIC_SIZE,
   parameter int unsigned ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     fault_wr_en,
   input  logic [ADDR_WIDTH-1:0]    fault_wr_row,
   input  logic [SYSTOLIC_SIZE-1:0] fault_wr_cols,
   input  logic                     load_done,
   input  logic                     weight_row_valid,
   input  logic [SYSTOLIC_SIZE-1:0] weight_zero_mask,
   output logic                     weight_row_ready,
   output logic [SYSTOLIC_SIZE-1:0] faulty_rows_mask,
   output logic                     envm_wr_en,
   output logic                     match_success,
   output logic                     match_failed,
   output logic                     all_faulty_matched,
   output logic [ADDR_WIDTH-1:0]    faulty_addr,
   output logic [ADDR_WIDTH-1:0]    current_row_addr,
   output logic                     busy,
   output logic                     done
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);

   state_t                   state;
   logic [SYSTOLIC_SIZE-1:0] fault_mask [SYSTOLIC_SIZE];
   logic [SYSTOLIC_SIZE-1:0] matched;
   logic [ADDR_WIDTH-1:0]    row_cnt;

   logic [SYSTOLIC_SIZE-1:0] unmatched;
   logic [SYSTOLIC_SIZE-1:0] candidates;
   logic [ADDR_WIDTH-1:0]    found_idx;
   logic                     found;

   assign unmatched = faulty_rows_mask & ~matched;

   // Row r can host the offered weight row if all its faulty columns see zero.
   // Evaluated on the acceptance cycle so the result registers land in ISSUE.
   always_comb begin
      candidates = '0;
      for (int r = 0; r < int'(SYSTOLIC_SIZE); r++) begin
         candidates[r] = unmatched[r] && ((fault_mask[r] & ~weight_zero_mask) == '0);
      end
   end

   fault_row_priority_finder #(
      .SYSTOLIC_SIZE (SYSTOLIC_SIZE),
      .ADDR_WIDTH    (ADDR_WIDTH)
   ) u_finder (
      .candidates (candidates),
      .index      (found_idx),
      .found      (found)
   );

   // Matcher FSM with registered outputs set on the edge entering each state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= ST_IDLE;
         for (int r = 0; r < int'(SYSTOLIC_SIZE); r++) fault_mask[r] <= '0;
         matched            <= '0;
         row_cnt            <= '0;
         weight_row_ready   <= 1'b0;
         faulty_rows_mask   <= '0;
         envm_wr_en         <= 1'b0;
         match_success      <= 1'b0;
         match_failed       <= 1'b0;
         all_faulty_matched <= 1'b0;
         faulty_addr        <= '0;
         current_row_addr   <= '0;
         busy               <= 1'b0;
         done               <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               // The row flag follows the write directly, so a write coincident
               // with load_done is already visible in COMMIT.
               if (fault_wr_en) begin
                  fault_mask[fault_wr_row]       <= fault_wr_cols;
                  faulty_rows_mask[fault_wr_row] <= |fault_wr_cols;
               end
               if (load_done) begin
                  state      <= ST_COMMIT;
                  envm_wr_en <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            ST_COMMIT: begin
               envm_wr_en       <= 1'b0;
               matched          <= '0;
               row_cnt          <= '0;
               weight_row_ready <= 1'b1;
               state            <= ST_WAIT_ROW;
            end
            ST_WAIT_ROW: begin
               if (weight_row_valid && weight_row_ready) begin
                  weight_row_ready <= 1'b0;
                  current_row_addr <= row_cnt;
                  state            <= ST_ISSUE;
                  if (found) begin
                     match_success      <= 1'b1;
                     faulty_addr        <= found_idx;
                     matched[found_idx] <= 1'b1;
                  end else if (|unmatched) begin
                     match_failed <= 1'b1;
                  end else begin
                     all_faulty_matched <= 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               match_success      <= 1'b0;
               match_failed       <= 1'b0;
               all_faulty_matched <= 1'b0;
               faulty_addr        <= '0;
               if (row_cnt == LAST_ROW) begin
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  row_cnt          <= row_cnt + ADDR_WIDTH'(1);
                  weight_row_ready <= 1'b1;
                  state            <= ST_WAIT_ROW;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
